// File: rtl/cache_cpu_port_if.sv
// Request/acknowledge channel between the CPU-bus responder and the cache core.
// The responder drives the request side (master); the cache core answers (slave).
interface cache_cpu_port_if #(
    parameter int CACHE_TAG_SIZE    = 10,
    parameter int CACHE_SET_SIZE    = 5,
    parameter int CACHE_OFFSET_SIZE = 4
);
    logic                         core_req;
    logic [2:0]                   core_cmd;
    logic [CACHE_TAG_SIZE-1:0]    core_tag;
    logic [CACHE_SET_SIZE-1:0]    core_set;
    logic [CACHE_OFFSET_SIZE-1:0] core_offset;
    logic [31:0]                  core_wdata;
    logic                         core_ack;
    logic [31:0]                  core_rdata;

    modport master (
        output core_req, core_cmd, core_tag, core_set, core_offset, core_wdata,
        input  core_ack, core_rdata
    );

    modport slave (
        input  core_req, core_cmd, core_tag, core_set, core_offset, core_wdata,
        output core_ack, core_rdata
    );
endinterface

// File: rtl/cache_cpu_port.sv
// Cache-side responder of the CPU bus: decodes two-tact A1/D1/C1 commands, hands
// them to the cache core over req/ack and answers on the shared bus with C1=7.
module cache_cpu_port #(
    parameter int CACHE_TAG_SIZE    = 10,
    parameter int CACHE_SET_SIZE    = 5,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int ADDR1_BUS_SIZE    = 15,
    parameter int DATA1_BUS_SIZE    = 16,
    parameter int CTR1_BUS_SIZE     = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [ADDR1_BUS_SIZE-1:0] A1,
    inout  wire  [DATA1_BUS_SIZE-1:0] D1,
    inout  wire  [CTR1_BUS_SIZE-1:0]  C1,
    cache_cpu_port_if.master          core,
    output logic                      busy
);
    localparam logic [2:0] CMD_NOP     = 3'd0;
    localparam logic [2:0] CMD_READ8   = 3'd1;
    localparam logic [2:0] CMD_READ16  = 3'd2;
    localparam logic [2:0] CMD_READ32  = 3'd3;
    localparam logic [2:0] CMD_INVAL   = 3'd4;
    localparam logic [2:0] CMD_WRITE8  = 3'd5;
    localparam logic [2:0] CMD_WRITE16 = 3'd6;
    localparam logic [2:0] CMD_WRITE32 = 3'd7;
    localparam logic [2:0] RESP_CODE   = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR2 = 3'd1,
        ST_CORE  = 3'd2,
        ST_RESP1 = 3'd3,
        ST_RESP2 = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    state_t                       state_r,  state_s;
    logic [2:0]                   cmd_r,    cmd_s;
    logic [CACHE_TAG_SIZE-1:0]    tag_r,    tag_s;
    logic [CACHE_SET_SIZE-1:0]    set_r,    set_s;
    logic [CACHE_OFFSET_SIZE-1:0] offset_r, offset_s;
    logic [DATA1_BUS_SIZE-1:0]    dlo_r,    dlo_s;
    logic [DATA1_BUS_SIZE-1:0]    dhi_r,    dhi_s;
    logic [31:0]                  rbuf_r,   rbuf_s;
    logic [31:0]                  wdata_r,  wdata_s;
    logic                         req_r,    req_s;
    logic                         busy_r,   busy_s;
    logic                         c_oe_r,   c_oe_s;
    logic                         d_oe_r,   d_oe_s;
    logic [DATA1_BUS_SIZE-1:0]    d_out_r,  d_out_s;

    // Bus halves arrive byte-swapped; write data is reassembled little-endian for the core.
    function automatic logic [31:0] assemble_wdata(input logic [2:0] cmd,
                                                   input logic [15:0] lo,
                                                   input logic [15:0] hi);
        logic [31:0] w;
        case (cmd)
            CMD_WRITE8:  w = {24'h00_0000, lo[7:0]};
            CMD_WRITE16: w = {16'h0000, lo[7:0], lo[15:8]};
            CMD_WRITE32: w = {hi[7:0], hi[15:8], lo[7:0], lo[15:8]};
            default:     w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    function automatic logic is_read(input logic [2:0] cmd);
        logic r;
        case (cmd)
            CMD_READ8, CMD_READ16, CMD_READ32: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    function automatic logic [15:0] resp1_word(input logic [2:0] cmd, input logic [31:0] rb);
        logic [15:0] w;
        case (cmd)
            CMD_READ8: w = {8'h00, rb[7:0]};
            default:   w = {rb[7:0], rb[15:8]};
        endcase
        return w;
    endfunction

    // Next-state and command latches; core_ack only matters in CORE.
    always_comb begin
        state_s  = state_r;
        cmd_s    = cmd_r;
        tag_s    = tag_r;
        set_s    = set_r;
        offset_s = offset_r;
        dlo_s    = dlo_r;
        dhi_s    = dhi_r;
        rbuf_s   = rbuf_r;
        wdata_s  = wdata_r;
        case (state_r)
            ST_IDLE: begin
                if (C1 != CMD_NOP) begin
                    cmd_s          = C1;
                    {tag_s, set_s} = A1;
                    dlo_s          = D1;
                    if (C1 == CMD_INVAL) begin
                        wdata_s = 32'h0000_0000;
                        state_s = ST_CORE;
                    end else begin
                        state_s = ST_ADDR2;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR2: begin
                offset_s = A1[CACHE_OFFSET_SIZE-1:0];
                dhi_s    = D1;
                wdata_s  = assemble_wdata(cmd_r, dlo_r, D1);
                state_s  = ST_CORE;
            end
            ST_CORE: begin
                if (core.core_ack) begin
                    rbuf_s  = core.core_rdata;
                    state_s = ST_RESP1;
                end else begin
                    state_s = ST_CORE;
                end
            end
            ST_RESP1: begin
                if (cmd_r == CMD_READ32) begin
                    state_s = ST_RESP2;
                end else begin
                    state_s = ST_GAP;
                end
            end
            ST_RESP2: state_s = ST_GAP;
            // Bus is deliberately not sampled here so our own C1=7 is never decoded.
            ST_GAP:   state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // Registered outputs decoded from the upcoming state so the bus drives cleanly from flops.
    always_comb begin
        req_s   = (state_s == ST_CORE);
        busy_s  = (state_s != ST_IDLE);
        c_oe_s  = (state_s == ST_RESP1) || (state_s == ST_RESP2);
        d_oe_s  = 1'b0;
        d_out_s = 16'h0000;
        case (state_s)
            ST_RESP1: begin
                if (is_read(cmd_s)) begin
                    d_oe_s  = 1'b1;
                    d_out_s = resp1_word(cmd_s, rbuf_s);
                end else begin
                    d_oe_s  = 1'b0;
                    d_out_s = 16'h0000;
                end
            end
            ST_RESP2: begin
                d_oe_s  = 1'b1;
                d_out_s = {rbuf_s[23:16], rbuf_s[31:24]};
            end
            default: begin
                d_oe_s  = 1'b0;
                d_out_s = 16'h0000;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            cmd_r    <= 3'd0;
            tag_r    <= '0;
            set_r    <= '0;
            offset_r <= '0;
            dlo_r    <= '0;
            dhi_r    <= '0;
            rbuf_r   <= 32'h0000_0000;
            wdata_r  <= 32'h0000_0000;
            req_r    <= 1'b0;
            busy_r   <= 1'b0;
            c_oe_r   <= 1'b0;
            d_oe_r   <= 1'b0;
            d_out_r  <= '0;
        end else begin
            state_r  <= state_s;
            cmd_r    <= cmd_s;
            tag_r    <= tag_s;
            set_r    <= set_s;
            offset_r <= offset_s;
            dlo_r    <= dlo_s;
            dhi_r    <= dhi_s;
            rbuf_r   <= rbuf_s;
            wdata_r  <= wdata_s;
            req_r    <= req_s;
            busy_r   <= busy_s;
            c_oe_r   <= c_oe_s;
            d_oe_r   <= d_oe_s;
            d_out_r  <= d_out_s;
        end
    end

    assign C1               = c_oe_r ? RESP_CODE : 3'bzzz;
    assign D1               = d_oe_r ? d_out_r : {DATA1_BUS_SIZE{1'bz}};
    assign core.core_req    = req_r;
    assign core.core_cmd    = cmd_r;
    assign core.core_tag    = tag_r;
    assign core.core_set    = set_r;
    assign core.core_offset = offset_r;
    assign core.core_wdata  = wdata_r;
    assign busy             = busy_r;
endmodule
